// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and parity helper.
// Also intended for the transmitter once it gains parity support.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Parity bit that makes the frame even (odd = 0) or odd (odd = 1).
    function automatic logic uart_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial receiver bundle: RX pin in, byte plus status strobes out.
// master is the receiver side, slave is the pin driver / byte consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 in_DataBit;
    logic [DATA_BITS-1:0] out_DataByte;
    logic                 out_fValid;
    logic                 out_fFrameErr;
    logic                 out_fParityErr;
    logic                 out_fBusy;

    modport master (
        input  in_DataBit,
        output out_DataByte,
        output out_fValid,
        output out_fFrameErr,
        output out_fParityErr,
        output out_fBusy
    );

    modport slave (
        output in_DataBit,
        input  out_DataByte,
        input  out_fValid,
        input  out_fFrameErr,
        input  out_fParityErr,
        input  out_fBusy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (idle line level).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and break suppression.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [13:0] KBAUD      = 14'd10416,
    parameter logic        PARITY_ODD = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);

    localparam int unsigned CntW = $clog2(KBAUD);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] HalfLoad = CntW'(KBAUD / 14'd2 - 14'd1);
    localparam logic [CntW-1:0] FullLoad = CntW'(KBAUD - 14'd1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);

    logic rx;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.in_DataBit),
        .q_o (rx)
    );

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic expired;
    assign expired = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rx) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx) begin
                    state_d = StIdle;   // start bit was a glitch
                end else begin
                    state_d = StData;
                    cnt_d   = FullLoad;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rx;
                    cnt_d          = FullLoad;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_d   = rx;
                    cnt_d   = FullLoad;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx) begin
                    byte_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                    perr_d  = (par_q != uart_parity(shift_q, PARITY_ODD));
`endif
                end else begin
                    ferr_d  = 1'b1;
                    state_d = StWaitHigh;
                end
            end
            StWaitHigh: begin
                // Hold off until the line idles so a break is not read as 0x00 frames.
                if (rx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.out_DataByte  = byte_q;
    assign bus.out_fValid    = valid_q;
    assign bus.out_fFrameErr = ferr_q;
    assign bus.out_fBusy     = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign bus.out_fParityErr = perr_q;
`else
    // perr_q stays 0 without a parity bit; parity sense has no effect here.
    assign bus.out_fParityErr = perr_q & PARITY_ODD;
`endif

endmodule
